envelope_vca: RTL and testbench
===============================

Name: envelope_vca

Overview:
- Voltage-controlled-amplifier stage that sits directly downstream of the ADSR envelope generator.
- Scales each oscillator sample by the current ADSR envelope value and passes the result to the mixer/DAC stage.
- Multiplication is a serial shift-add, one multiplier bit per clock, to keep area small.
- Sample-level valid/ready handshake on both input and output.

Parameters:
- WAVE_DEPTH, 8, bit width of samples and envelope values.
- WAVE_MAX, (1<<WAVE_DEPTH)-1, full-scale sample/envelope value (derived; not overridden).

Ports:
- Clock  input  1  system clock; all state updates on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- SampleIn  input  WAVE_DEPTH  unsigned oscillator sample.
- SampleValid  input  1  SampleIn is valid this cycle.
- SampleReady  output  1  block can accept a sample this cycle.
- Envolope  input  WAVE_DEPTH  unsigned envelope level from the ADSR stage.
- SampleOut  output  WAVE_DEPTH  scaled sample.
- OutValid  output  1  SampleOut holds a new result.
- OutReady  input  1  downstream accepts SampleOut this cycle.

Behaviour:
- Reset: asynchronous and active-high.
  - While Reset=1: state=IDLE, SampleOut=0, OutValid=0, bit counter=0, accumulator=0, latched operands=0.
  - SampleReady is 0 while Reset=1.
  - Any multiply in progress is discarded; no partial result appears after Reset deasserts.
- Arithmetic:
  - SampleOut = (SampleIn * (Envolope+1)) >> WAVE_DEPTH.
  - Multiplier Envolope+1 is WAVE_DEPTH+1 bits wide. Accumulator is 2*WAVE_DEPTH+1 bits wide; no overflow is possible.
  - Boundary results: Envolope=0 gives 0 for every sample; Envolope=WAVE_MAX gives exactly SampleIn. Result is truncated (floor), never rounded, never saturated.
- States: IDLE, MUL, DONE.
- IDLE:
  - SampleReady=1.
  - On a rising edge with SampleValid=1: latch SampleIn and Envolope+1, clear the accumulator, set counter=0, go to MUL.
- MUL:
  - SampleReady=0.
  - Each edge consumes one multiplier bit, LSB first: if the bit is 1, the accumulator adds the multiplicand shifted left by the counter value; then counter increments.
  - After exactly WAVE_DEPTH+1 MUL edges, on the last MUL edge: SampleOut is loaded with accumulator bits [2*WAVE_DEPTH-1:WAVE_DEPTH] (including the final partial product), OutValid goes to 1, state goes to DONE.
- Latency: accept edge N gives OutValid=1 and a valid SampleOut immediately after edge N+WAVE_DEPTH+1 (9 cycles for WAVE_DEPTH=8).
- DONE:
  - SampleReady=0; OutValid=1 and SampleOut are held stable.
  - On an edge with OutReady=1: OutValid goes to 0 and state goes to IDLE.
  - OutReady=0 stalls indefinitely with no data change.
- Throughput: one sample per WAVE_DEPTH+3 cycles at best. A new sample is never accepted in the same edge as the output handshake.
- Operand stability: changes on Envolope or SampleIn after the accept edge have no effect on the in-flight result.
- SampleOut after handshake: keeps its last value until the next completion; only OutValid qualifies it.
- Ignored inputs: SampleValid while not in IDLE, and OutReady outside DONE.
- No X propagation: every register has a reset value.

Test Plan:
- Reset pulse, then SampleIn=200, Envolope=255, SampleValid for 1 cycle at edge N -> OutValid high after edge N+9, SampleOut=200.
- SampleIn=255, Envolope=127 -> SampleOut=127; SampleIn=255, Envolope=0 -> SampleOut=0; SampleIn=0, Envolope=255 -> SampleOut=0.
- SampleIn=100, Envolope=64, OutReady held low 5 cycles after OutValid -> SampleOut=25 held stable, OutValid=1, SampleReady=0 throughout; OutReady=1 -> OutValid=0 next edge, SampleReady=1.
- Envolope switches 255->0 two cycles after accepting SampleIn=180 with Envolope=255 -> SampleOut=180 (latched operand used).
- Reset asserted asynchronously mid-MUL (counter=4) -> SampleOut=0, OutValid=0, SampleReady=0 immediately; after release, no output appears without a new sample; SampleReady=1 on the first cycle after release.
- Back-to-back stream of 16 random samples/envelopes with random OutReady -> every output matches (S*(E+1))>>8, in order, none dropped or duplicated.

Source files
------------

// File: rtl/envelope_vca_if.sv
// Sample-level handshake bundle between oscillator, envelope VCA and mixer.
// master drives samples/envelope and OutReady; slave is the VCA itself.
interface envelope_vca_if #(
  parameter int WAVE_DEPTH = 8
);
  logic [WAVE_DEPTH-1:0] SampleIn;
  logic                  SampleValid;
  logic                  SampleReady;
  logic [WAVE_DEPTH-1:0] Envolope;
  logic [WAVE_DEPTH-1:0] SampleOut;
  logic                  OutValid;
  logic                  OutReady;

  modport master (
    output SampleIn, SampleValid, Envolope, OutReady,
    input  SampleReady, SampleOut, OutValid
  );

  modport slave (
    input  SampleIn, SampleValid, Envolope, OutReady,
    output SampleReady, SampleOut, OutValid
  );
endinterface

// File: rtl/envelope_vca.sv
// Envelope VCA: SampleOut = (SampleIn * (Envolope+1)) >> WAVE_DEPTH,
// computed by a serial shift-add consuming one multiplier bit per clock.
//
// state | meaning
// IDLE  | ready for a new sample
// MUL   | shift-add in progress, one multiplier bit per edge
// DONE  | result valid, waiting for OutReady
module envelope_vca #(
  parameter int WAVE_DEPTH = 8
) (
  input  logic          Clock,
  input  logic          Reset,
  envelope_vca_if.slave vca
);
  localparam int ACC_W = 2 * WAVE_DEPTH + 1;
  localparam int CNT_W = $clog2(WAVE_DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WAVE_DEPTH);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t                state;
  logic [WAVE_DEPTH-1:0] mcand;
  logic [WAVE_DEPTH:0]   mplier;
  logic [CNT_W-1:0]      cnt;
  logic [ACC_W-1:0]      acc;
  logic [ACC_W-1:0]      partial;
  logic [ACC_W-1:0]      acc_sum;
  logic [WAVE_DEPTH-1:0] sample_out;
  logic                  out_valid;

  always_comb begin
    partial = '0;
    if (mplier[cnt])
      partial = ACC_W'(mcand) << cnt;
    acc_sum = acc + partial;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
      acc        <= '0;
      sample_out <= '0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (vca.SampleValid) begin
            mcand  <= vca.SampleIn;
            mplier <= (WAVE_DEPTH+1)'(vca.Envolope) + (WAVE_DEPTH+1)'(1);
            acc    <= '0;
            cnt    <= '0;
            state  <= MUL;
          end
        end
        MUL: begin
          acc <= acc_sum;
          cnt <= cnt + CNT_W'(1);
          // the final partial product is folded in directly from acc_sum
          if (cnt == LAST_BIT) begin
            sample_out <= acc_sum[2*WAVE_DEPTH-1:WAVE_DEPTH];
            out_valid  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (vca.OutReady) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign vca.SampleReady = (state == IDLE) && !Reset;
  assign vca.SampleOut   = sample_out;
  assign vca.OutValid    = out_valid;
endmodule

// File: tb/tb_envelope_vca.sv
// Self-checking bench for envelope_vca: directed boundary cases plus a random
// stream compared against an arithmetic reference (S*(E+1))>>8.
module tb_envelope_vca;
  localparam int WAVE_DEPTH = 8;
  localparam int WAVE_MAX   = (1 << WAVE_DEPTH) - 1;
  localparam int N_RAND     = 16;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  envelope_vca_if #(.WAVE_DEPTH(WAVE_DEPTH)) vif ();

  envelope_vca #(.WAVE_DEPTH(WAVE_DEPTH)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .vca   (vif.slave)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  function automatic int ref_vca(int s, int e);
    return (s * (e + 1)) >> WAVE_DEPTH;
  endfunction

  task automatic chk(string tag, int obs, int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic accept(int s, int e);
    @(negedge Clock);
    vif.SampleIn    = s[WAVE_DEPTH-1:0];
    vif.Envolope    = e[WAVE_DEPTH-1:0];
    vif.SampleValid = 1'b1;
    chk("accept_ready", int'(vif.SampleReady), 1);
    @(posedge Clock);
    #1;
    vif.SampleValid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!vif.OutValid && lat < 40) begin
      @(posedge Clock);
      #1;
      lat++;
    end
    if (!vif.OutValid) chk("out_timeout", 0, 1);
  endtask

  task automatic handshake();
    @(negedge Clock);
    vif.OutReady = 1'b1;
    @(posedge Clock);
    #1;
    vif.OutReady = 1'b0;
    chk("ov_clear", int'(vif.OutValid), 0);
    chk("ready_back", int'(vif.SampleReady), 1);
  endtask

  task automatic run_one(string tag, int s, int e);
    int lat;
    accept(s, e);
    wait_out(lat);
    chk({tag, "_lat"}, lat, WAVE_DEPTH + 1);
    chk({tag, "_val"}, int'(vif.SampleOut), ref_vca(s, e));
    handshake();
  endtask

  initial begin
    int lat;
    int ghost;
    int got;
    int guard;
    vif.SampleIn    = '0;
    vif.Envolope    = '0;
    vif.SampleValid = 1'b0;
    vif.OutReady    = 1'b0;

    #12;
    chk("rst_out", int'(vif.SampleOut), 0);
    chk("rst_ov", int'(vif.OutValid), 0);
    chk("rst_ready", int'(vif.SampleReady), 0);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    chk("rel_ready", int'(vif.SampleReady), 1);

    run_one("full_env", 200, WAVE_MAX);
    chk("full_env_model", ref_vca(200, WAVE_MAX), 200);
    run_one("half_env", 255, 127);
    run_one("zero_env", 255, 0);
    run_one("zero_smp", 0, WAVE_MAX);

    // stall: result must hold while OutReady is low
    accept(100, 64);
    wait_out(lat);
    chk("stall_lat", lat, WAVE_DEPTH + 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge Clock);
      #1;
      chk("stall_out", int'(vif.SampleOut), 25);
      chk("stall_ov", int'(vif.OutValid), 1);
      chk("stall_ready", int'(vif.SampleReady), 0);
    end
    handshake();
    chk("post_hs_hold", int'(vif.SampleOut), 25);

    // operand stability: envelope drops to 0 two cycles after accept
    accept(180, WAVE_MAX);
    @(posedge Clock);
    #1;
    vif.Envolope = '0;
    wait_out(lat);
    chk("latch_lat", lat + 1, WAVE_DEPTH + 1);
    chk("latch_val", int'(vif.SampleOut), 180);
    handshake();

    // asynchronous reset in the middle of a multiply
    accept(200, WAVE_MAX);
    repeat (4) @(posedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    chk("arst_out", int'(vif.SampleOut), 0);
    chk("arst_ov", int'(vif.OutValid), 0);
    chk("arst_ready", int'(vif.SampleReady), 0);
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    #1;
    chk("arst_rel_ready", int'(vif.SampleReady), 1);
    ghost = 0;
    repeat (15) begin
      @(negedge Clock);
      if (vif.OutValid) ghost++;
    end
    chk("arst_no_ghost", ghost, 0);

    // random stream with random downstream back-pressure
    got = 0;
    fork
      begin
        for (int i = 0; i < N_RAND; i++) begin
          int s;
          int e;
          int w;
          s = int'($urandom_range(0, WAVE_MAX));
          e = int'($urandom_range(0, WAVE_MAX));
          @(negedge Clock);
          vif.SampleIn    = s[WAVE_DEPTH-1:0];
          vif.Envolope    = e[WAVE_DEPTH-1:0];
          vif.SampleValid = 1'b1;
          w = 0;
          while (!vif.SampleReady && w < 200) begin
            @(negedge Clock);
            w++;
          end
          if (!vif.SampleReady) chk("drv_timeout", 0, 1);
          exp_q.push_back(ref_vca(s, e));
          @(negedge Clock);
          vif.SampleValid = 1'b0;
          vif.Envolope    = WAVE_DEPTH'($urandom_range(0, WAVE_MAX));
        end
      end
      begin
        guard = 0;
        while (got < N_RAND && guard < 5000) begin
          @(negedge Clock);
          guard++;
          vif.OutReady = 1'($urandom_range(0, 1));
          if (vif.OutValid && vif.OutReady) begin
            if (exp_q.size() == 0) begin
              chk("rnd_extra", 1, 0);
            end else begin
              chk("rnd_val", int'(vif.SampleOut), exp_q.pop_front());
            end
            got++;
          end
        end
        @(negedge Clock);
        vif.OutReady = 1'b0;
      end
    join
    chk("rnd_count", got, N_RAND);
    chk("rnd_leftover", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
